// File: rtl/merge_stream_node.sv
// Two-way sorted merge node with an output FIFO.
// Runs are delimited by an all-ones sentinel.
module merge_stream_node #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 2,
  parameter bit DESCEND = 1'b1,
  parameter int CWIDTH  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DWIDTH-1:0] In1,
  input  logic              In1Valid,
  output logic              Read1,
  input  logic [DWIDTH-1:0] In2,
  input  logic              In2Valid,
  output logic              Read2,
  output logic [DWIDTH-1:0] Out,
  output logic              OutValid,
  input  logic              OutRead,
  output logic [AWIDTH:0]   Level,
  output logic [CWIDTH-1:0] RunCount,
  output logic              RunDone
);

  localparam logic [AWIDTH:0] DEPTH =
    (AWIDTH+1)'(1 << AWIDTH);
  localparam logic [DWIDTH-1:0] SENT = '1;

  logic [DWIDTH-1:0] mem [1<<AWIDTH];
  logic [AWIDTH-1:0] wptr;
  logic [AWIDTH-1:0] rptr;
  logic [DWIDTH-1:0] din;
  logic              s1;
  logic              s2;
  logic              take1;
  logic              pop;
  logic              space;
  logic              fire;

  assign OutValid = (Level != '0);
  assign Out      = OutValid ? mem[rptr] : SENT;
  assign pop      = OutRead && OutValid;
  assign space    = (Level < DEPTH) || pop;
  assign fire     = In1Valid && In2Valid
                    && space && !Reset;
  assign s1       = (In1 == SENT);
  assign s2       = (In2 == SENT);
  assign take1    = DESCEND ? (In1 > In2)
                            : (In1 < In2);

  // Ties fall through to stream 2
  always_comb begin
    Read1 = 1'b0;
    Read2 = 1'b0;
    din   = SENT;
    if (fire) begin
      unique case (1'b1)
        s1 && s2: begin
          Read1 = 1'b1;
          Read2 = 1'b1;
        end
        s1 && !s2: begin
          Read2 = 1'b1;
          din   = In2;
        end
        !s1 && s2: begin
          Read1 = 1'b1;
          din   = In1;
        end
        !s1 && !s2 && take1: begin
          Read1 = 1'b1;
          din   = In1;
        end
        default: begin
          Read2 = 1'b1;
          din   = In2;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (fire) mem[wptr] <= din;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wptr     <= '0;
      rptr     <= '0;
      Level    <= '0;
      RunCount <= '0;
      RunDone  <= 1'b0;
    end else begin
      RunDone <= fire && (din == SENT);
      if (fire) wptr <= wptr + AWIDTH'(1);
      if (pop)  rptr <= rptr + AWIDTH'(1);
      if (fire && !pop)
        Level <= Level + (AWIDTH+1)'(1);
      else if (!fire && pop)
        Level <= Level - (AWIDTH+1)'(1);
      if (fire) begin
        if (din == SENT)
          RunCount <= '0;
        else if (RunCount != '1)
          RunCount <= RunCount + CWIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_merge_stream_node.sv
// Bench for merge_stream_node: vector table, directed
// sequences and randomized runs against a sort model.
module tb_merge_stream_node;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam int CW = 16;
  localparam logic [DW-1:0] S = '1;

  typedef logic [DW-1:0] dq_t[$];

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    bit va;
    bit vb;
    bit r1;
    bit r2;
    bit ov;
    logic [DW-1:0] o;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0] in1, in2;
  logic v1, v2, oread;
  logic [1:0] rd1, rd2, ov, rdn;
  logic [DW-1:0] out [2];
  logic [AW:0] lvl [2];
  logic [CW-1:0] rc [2];

  int total = 0;
  int bad = 0;
  int sel = 0;
  int donecnt = 0;
  bit last_r1, last_r2;
  dq_t q1, q2, eq;
  logic [CW-1:0] rcq[$];
  vec_t tbl [9];

  always #5 clk = ~clk;

  merge_stream_node #(
    .DWIDTH(DW), .AWIDTH(AW),
    .DESCEND(1'b1), .CWIDTH(CW)
  ) u_dsc (
    .Clk(clk), .Reset(rst),
    .In1(in1), .In1Valid(v1), .Read1(rd1[0]),
    .In2(in2), .In2Valid(v2), .Read2(rd2[0]),
    .Out(out[0]), .OutValid(ov[0]),
    .OutRead(oread), .Level(lvl[0]),
    .RunCount(rc[0]), .RunDone(rdn[0])
  );

  merge_stream_node #(
    .DWIDTH(DW), .AWIDTH(AW),
    .DESCEND(1'b0), .CWIDTH(CW)
  ) u_asc (
    .Clk(clk), .Reset(rst),
    .In1(in1), .In1Valid(v1), .Read1(rd1[1]),
    .In2(in2), .In2Valid(v2), .Read2(rd2[1]),
    .Out(out[1]), .OutValid(ov[1]),
    .OutRead(oread), .Level(lvl[1]),
    .RunCount(rc[1]), .RunDone(rdn[1])
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v1 = 1'b0;
    v2 = 1'b0;
    oread = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q1.delete();
    q2.delete();
    eq.delete();
    rcq.delete();
    donecnt = 0;
  endtask

  // Model: a run's output is the sorted union of both
  // runs' data followed by one sentinel.
  task automatic add_run(input dq_t a, input dq_t b);
    dq_t m;
    foreach (a[i]) begin
      q1.push_back(a[i]);
      m.push_back(a[i]);
    end
    foreach (b[i]) begin
      q2.push_back(b[i]);
      m.push_back(b[i]);
    end
    q1.push_back(S);
    q2.push_back(S);
    if (sel == 0) m.rsort();
    else m.sort();
    foreach (m[i]) eq.push_back(m[i]);
    eq.push_back(S);
  endtask

  task automatic rand_run();
    dq_t a, b;
    int n1, n2;
    n1 = $urandom_range(0, 5);
    n2 = $urandom_range(0, 5);
    for (int i = 0; i < n1; i++)
      a.push_back(DW'($urandom_range(0, 40)));
    for (int i = 0; i < n2; i++)
      b.push_back(DW'($urandom_range(0, 40)));
    if (sel == 0) begin
      a.rsort();
      b.rsort();
    end else begin
      a.sort();
      b.sort();
    end
    add_run(a, b);
  endtask

  task automatic tick(input bit g1, input bit g2,
                      input bit rd);
    logic [DW-1:0] o;
    bit r1, r2, ovl;
    v1 = g1 && (q1.size() > 0);
    v2 = g2 && (q2.size() > 0);
    in1 = (q1.size() > 0) ? q1[0] : '0;
    in2 = (q2.size() > 0) ? q2[0] : '0;
    oread = rd;
    @(negedge clk);
    r1 = rd1[sel];
    r2 = rd2[sel];
    ovl = ov[sel];
    o = out[sel];
    last_r1 = r1;
    last_r2 = r2;
    if (rdn[sel]) donecnt++;
    if (r1 && r2) rcq.push_back(rc[sel]);
    if (v1 && v2 && in1 == in2 && in1 != S)
      chk("tie_read1", r1, 0);
    if (r1 && r2)
      chk("dual_read", (in1 == S) && (in2 == S), 1);
    if (ovl && rd) begin
      if (eq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_out got=%0h want=none", o);
      end else begin
        chk("out", o, eq.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (r1 && q1.size() > 0) void'(q1.pop_front());
    if (r2 && q2.size() > 0) void'(q2.pop_front());
  endtask

  task automatic drain(input int maxc, input bit rnd);
    int n;
    n = 0;
    while (eq.size() > 0 && n < maxc) begin
      if (rnd)
        tick($urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) != 0);
      else
        tick(1'b1, 1'b1, 1'b1);
      n++;
    end
    chk("drain_left", eq.size(), 0);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    chk("drain_level", lvl[sel], 0);
  endtask

  initial begin
    dq_t a, b;
    tbl[0] = '{32'd9, 32'd8, 1, 1, 1, 0, 1, 32'd9};
    tbl[1] = '{32'd3, 32'd7, 1, 1, 0, 1, 1, 32'd7};
    tbl[2] = '{32'd5, 32'd5, 1, 1, 0, 1, 1, 32'd5};
    tbl[3] = '{S, 32'd4, 1, 1, 0, 1, 1, 32'd4};
    tbl[4] = '{32'd4, S, 1, 1, 1, 0, 1, 32'd4};
    tbl[5] = '{32'd6, 32'd2, 1, 0, 0, 0, 0, S};
    tbl[6] = '{32'd6, 32'd2, 0, 1, 0, 0, 0, S};
    tbl[7] = '{S, S, 1, 1, 1, 1, 1, S};
    tbl[8] = '{32'd0, 32'hffff_fffe, 1, 1, 0, 1, 1,
               32'hffff_fffe};

    // reset state, reads held low under reset
    sel = 0;
    rst = 1'b1;
    v1 = 1'b1;
    v2 = 1'b1;
    in1 = 32'd5;
    in2 = 32'd3;
    oread = 1'b1;
    @(negedge clk);
    chk("rst_read1", rd1[0], 0);
    chk("rst_read2", rd2[0], 0);
    @(posedge clk);
    #1;
    chk("rst_level", lvl[0], 0);
    chk("rst_ovalid", ov[0], 0);
    chk("rst_out", out[0], S);
    chk("rst_runcount", rc[0], 0);
    chk("rst_rundone", rdn[0], 0);
    rst = 1'b0;

    // selection table, descending node, consumer always ready
    foreach (tbl[i]) begin
      in1 = tbl[i].a;
      in2 = tbl[i].b;
      v1 = tbl[i].va;
      v2 = tbl[i].vb;
      oread = 1'b1;
      @(negedge clk);
      chk($sformatf("tbl%0d_read1", i), rd1[0], tbl[i].r1);
      chk($sformatf("tbl%0d_read2", i), rd2[0], tbl[i].r2);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_ovalid", i), ov[0], tbl[i].ov);
      chk($sformatf("tbl%0d_out", i), out[0], tbl[i].o);
    end

    // descending single run
    sel = 0;
    do_reset();
    a = {32'd9, 32'd5, 32'd2};
    b = {32'd8, 32'd7, 32'd1};
    add_run(a, b);
    drain(100, 1'b0);
    chk("r1_done", donecnt, 1);
    chk("r1_termcnt", rcq.size(), 1);
    if (rcq.size() > 0) chk("r1_runcount", rcq[0], 6);
    chk("r1_rc_clear", rc[0], 0);

    // ascending with a tie
    sel = 1;
    do_reset();
    a = {32'd1, 32'd4};
    b = {32'd4, 32'd6};
    add_run(a, b);
    drain(100, 1'b0);
    chk("r2_done", donecnt, 1);

    // full FIFO back-pressure
    sel = 0;
    do_reset();
    q1 = {32'd9, 32'd5, 32'd2};
    q2 = {32'd8, 32'd7, 32'd1};
    eq = {32'd9, 32'd8, 32'd7, 32'd5, 32'd2, 32'd1};
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0);
    chk("full_level", lvl[0], 4);
    chk("full_ovalid", ov[0], 1);
    chk("full_pushes", q1.size() + q2.size(), 2);
    tick(1'b1, 1'b1, 1'b0);
    chk("full_read1", last_r1, 0);
    chk("full_read2", last_r2, 0);
    tick(1'b1, 1'b1, 1'b1);
    chk("popush_read", last_r1 | last_r2, 1);
    chk("popush_level", lvl[0], 4);
    q1.push_back(S);
    q2.push_back(S);
    eq.push_back(S);
    drain(100, 1'b0);

    // back-to-back runs
    sel = 0;
    do_reset();
    a = {32'd3};
    b = {32'd2};
    add_run(a, b);
    a = {32'd7};
    b = {32'd5};
    add_run(a, b);
    drain(100, 1'b0);
    chk("b2b_done", donecnt, 2);
    chk("b2b_terms", rcq.size(), 2);
    foreach (rcq[i]) chk($sformatf("b2b_rc%0d", i), rcq[i], 2);

    // stream 2 stalled
    sel = 0;
    do_reset();
    a = {32'd4};
    b = {32'd3};
    add_run(a, b);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 1'b1);
      chk("stall_read1", last_r1, 0);
    end
    chk("stall_level", lvl[0], 0);
    chk("stall_q1", q1.size(), 2);
    drain(100, 1'b0);

    // reset mid-run
    sel = 0;
    do_reset();
    a = {32'd9, 32'd5, 32'd2};
    b = {32'd8, 32'd7, 32'd1};
    add_run(a, b);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
    chk("mid_level", lvl[0], 3);
    chk("mid_runcount", rc[0], 3);
    rst = 1'b1;
    v1 = 1'b1;
    v2 = 1'b1;
    oread = 1'b1;
    @(negedge clk);
    chk("mid_rst_read1", rd1[0], 0);
    chk("mid_rst_read2", rd2[0], 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    v1 = 1'b0;
    v2 = 1'b0;
    chk("mid_level0", lvl[0], 0);
    chk("mid_ovalid", ov[0], 0);
    chk("mid_out", out[0], S);
    chk("mid_rc0", rc[0], 0);
    chk("mid_rdone", rdn[0], 0);
    @(negedge clk);
    chk("mid_rdone_next", rdn[0], 0);
    @(posedge clk);
    #1;

    // randomized runs, both directions
    for (int s = 0; s < 2; s++) begin
      sel = s;
      do_reset();
      for (int r = 0; r < 8; r++) rand_run();
      drain(3000, 1'b1);
      chk($sformatf("rnd%0d_done", s), donecnt, 8);
      chk($sformatf("rnd%0d_q1", s), q1.size(), 0);
      chk($sformatf("rnd%0d_q2", s), q2.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/merge_stream_node.md
Name: merge_stream_node

Overview:
- Parameterised, buffered successor to the single-register merge-tree nodes.
- Merges two sorted input streams into one sorted output stream, ascending or descending.
- Holds results in a DEPTH-entry output FIFO, so back-pressure does not ripple combinationally up the tree.
- Supports multiple back-to-back runs delimited by an all-ones sentinel; sits at any interior level of the merge tree.

Parameters:
- DWIDTH, 32, key width; the all-ones value is the end-of-run sentinel and is not legal data.
- AWIDTH, 2, FIFO address width; DEPTH = 1<<AWIDTH entries, AWIDTH >= 1.
- DESCEND, 1, 1 = largest first (legacy tree order), 0 = smallest first.
- CWIDTH, 16, width of the per-run element counter.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- In1  in  DWIDTH  head of input stream 1.
- In1Valid  in  1  In1 holds a valid head (data or sentinel).
- Read1  out  1  combinational pop of stream 1 this cycle.
- In2  in  DWIDTH  head of input stream 2.
- In2Valid  in  1  In2 holds a valid head.
- Read2  out  1  combinational pop of stream 2 this cycle.
- Out  out  DWIDTH  FIFO head; all-ones when empty.
- OutValid  out  1  FIFO non-empty.
- OutRead  in  1  consumer pops Out this cycle; ignored when OutValid=0.
- Level  out  AWIDTH+1  FIFO occupancy, 0..DEPTH.
- RunCount  out  CWIDTH  non-sentinel elements pushed in current run.
- RunDone  out  1  registered one-cycle pulse after a run's sentinel is pushed.

Behaviour:
- Clk is the only clock. Reset is synchronous, active-high, and wins over all other activity.
- Reset values:
  - FIFO empty: Level=0, OutValid=0, Out=all-ones.
  - RunCount=0, RunDone=0.
  - Read1=Read2=0 while Reset is high.
- Space: space = (Level<DEPTH) || (OutRead && OutValid). Simultaneous push and pop is allowed while full.
- Fire: fire = In1Valid && In2Valid && space && !Reset. No decision is made with only one input valid.
- Selection when fire (S = all-ones):
  - In1==S and In2==S: push S; Read1=Read2=1 (terminal case).
  - In1==S only: push In2, Read2=1.
  - In2==S only: push In1, Read1=1.
  - Neither is S, DESCEND=1: In1>In2 -> push In1, Read1=1; else push In2, Read2=1. Ties take In2.
  - Neither is S, DESCEND=0: In1<In2 -> push In1, Read1=1; else push In2, Read2=1. Ties take In2.
- Comparisons are unsigned, full DWIDTH.
- At most one element is pushed per cycle. Read1 and Read2 are both high only in the terminal case.
- Latency: a pushed element is visible on Out one cycle after the push edge if the FIFO was empty; otherwise it appears in FIFO order.
- FIFO:
  - Circular buffer with AWIDTH-bit read/write pointers that wrap modulo DEPTH.
  - Level tracks push minus pop.
  - Pop on an empty FIFO is ignored.
  - Push with no space cannot occur, because fire is gated.
- RunCount:
  - Increments on each non-sentinel push and saturates at all-ones.
  - On a sentinel push, clears to 0 at the same edge and RunDone=1 for the next cycle only.
- Sentinels are stored in and emitted through the FIFO like data, so downstream nodes see run boundaries in order.
- Reset mid-run discards FIFO contents and the partial count. No RunDone pulse is generated by Reset.
- All outputs except Read1/Read2 are registered or decoded directly from FIFO state.

Test Plan:
- DESCEND=1, stream1 = 9,5,2,S; stream2 = 8,7,1,S; OutRead=1 always -> Out sequence 9,8,7,5,2,1,S. RunCount reaches 6 then clears; RunDone pulses once, the cycle after S is pushed.
- DESCEND=0, stream1 = 1,4,S; stream2 = 4,6,S -> Out 1,4(stream2),4(stream1),6,S. Verify tie takes In2 via Read2 timing.
- AWIDTH=2, OutRead=0, both streams valid with 6 data elements -> exactly 4 pushes; Level=4; Read1=Read2=0 after that. Raise OutRead for 1 cycle -> simultaneous pop and push; Level stays 4.
- Two back-to-back runs: (3,S | 2,S) then (7,S | 5,S) -> Out 3,2,S,7,5,S. RunDone pulses twice; RunCount=2 before each clear.
- In2Valid=0 for 5 cycles with In1Valid=1 -> no Read1, no push; resumes correctly when In2Valid rises.
- Reset asserted with Level=3, RunCount=3 -> next cycle Level=0, OutValid=0, Out=all-ones, RunCount=0, RunDone=0. Read1/Read2 stay low during Reset.
